// File: rtl/seg7_reader.sv
// Reads a multiplexed, active-low 7-segment display and rebuilds the
// 8-digit hex value it shows, one debounced digit at a time.
module seg7_reader #(
  parameter int unsigned STABLE  = 4,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [6:0]  Seg,
  input  logic [7:0]  DigitSel,
  input  logic        Capture,
  output logic [31:0] Word,
  output logic        Valid,
  output logic        Busy,
  output logic [7:0]  ErrMask,
  output logic        Timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [7:0]  STAB_MAX = 8'(STABLE - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  // {valid, nibble} for an active-high g..a pattern
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    case (pat)
      7'h3F:   seg_decode = {1'b1, 4'h0};
      7'h06:   seg_decode = {1'b1, 4'h1};
      7'h5B:   seg_decode = {1'b1, 4'h2};
      7'h4F:   seg_decode = {1'b1, 4'h3};
      7'h66:   seg_decode = {1'b1, 4'h4};
      7'h6D:   seg_decode = {1'b1, 4'h5};
      7'h7D:   seg_decode = {1'b1, 4'h6};
      7'h07:   seg_decode = {1'b1, 4'h7};
      7'h7F:   seg_decode = {1'b1, 4'h8};
      7'h6F:   seg_decode = {1'b1, 4'h9};
      7'h77:   seg_decode = {1'b1, 4'hA};
      7'h7C:   seg_decode = {1'b1, 4'hB};
      7'h39:   seg_decode = {1'b1, 4'hC};
      7'h5E:   seg_decode = {1'b1, 4'hD};
      7'h79:   seg_decode = {1'b1, 4'hE};
      7'h71:   seg_decode = {1'b1, 4'hF};
      default: seg_decode = {1'b0, 4'h0};
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [6:0]  seg_q, seg_prev_q;
  logic [7:0]  sel_q, sel_prev_q;
  logic [7:0]  stab_q, stab_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  captured_q, captured_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic [7:0]  err_q, err_d;
  logic        timeout_q, timeout_d;

  logic        one_low;
  logic [2:0]  dig_idx;
  logic        same_smp;
  logic [4:0]  decoded;

  // Next-state, capture and output computation
  always_comb begin
    state_d    = state_q;
    stab_d     = stab_q;
    tmo_d      = tmo_q;
    captured_d = captured_q;
    shadow_d   = shadow_q;
    word_d     = word_q;
    err_d      = err_q;
    timeout_d  = timeout_q;
    one_low    = 1'b1;
    dig_idx    = 3'd0;
    same_smp   = ({seg_q, sel_q} == {seg_prev_q, sel_prev_q});
    decoded    = seg_decode(~seg_q);

    case (sel_q)
      8'hFE:   dig_idx = 3'd0;
      8'hFD:   dig_idx = 3'd1;
      8'hFB:   dig_idx = 3'd2;
      8'hF7:   dig_idx = 3'd3;
      8'hEF:   dig_idx = 3'd4;
      8'hDF:   dig_idx = 3'd5;
      8'hBF:   dig_idx = 3'd6;
      8'h7F:   dig_idx = 3'd7;
      default: one_low = 1'b0;
    endcase

    case (state_q)
      S_IDLE: begin
        if (Capture) begin
          captured_d = 8'h00;
          err_d      = 8'h00;
          timeout_d  = 1'b0;
          stab_d     = 8'd0;
          tmo_d      = 16'd0;
          shadow_d   = 32'h0000_0000;
          state_d    = S_COLLECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COLLECT: begin
        tmo_d = tmo_q + 16'd1;
        if (!one_low) begin
          stab_d = 8'd0;
        end else if (same_smp && (stab_q == STAB_MAX) && !captured_q[dig_idx]) begin
          // An invalid pattern still closes the digit, recorded as zero
          shadow_d[{dig_idx, 2'b00} +: 4] = decoded[3:0];
          err_d[dig_idx]                  = ~decoded[4];
          captured_d[dig_idx]             = 1'b1;
          stab_d                          = 8'd0;
        end else if (same_smp) begin
          stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 8'd1;
        end else begin
          stab_d = 8'd0;
        end

        if (captured_d == 8'hFF) begin
          state_d = S_DONE;
          word_d  = shadow_d;
        end else if (tmo_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    valid_d = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  // State, input stage and output registers
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      seg_q      <= 7'h7F;
      sel_q      <= 8'hFF;
      seg_prev_q <= 7'h7F;
      sel_prev_q <= 8'hFF;
      stab_q     <= 8'd0;
      tmo_q      <= 16'd0;
      captured_q <= 8'h00;
      shadow_q   <= 32'h0000_0000;
      word_q     <= 32'h0000_0000;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 8'h00;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_q      <= Seg;
      sel_q      <= DigitSel;
      seg_prev_q <= seg_q;
      sel_prev_q <= sel_q;
      stab_q     <= stab_d;
      tmo_q      <= tmo_d;
      captured_q <= captured_d;
      shadow_q   <= shadow_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
    end
  end

  assign Word    = word_q;
  assign Valid   = valid_q;
  assign Busy    = busy_q;
  assign ErrMask = err_q;
  assign Timeout = timeout_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: scans a simulated display and checks the
// reassembled word, error mask, timeout and reset behaviour.
module tb_seg7_reader;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [6:0]  Seg;
  logic [7:0]  DigitSel;
  logic        Capture;
  logic [31:0] Word;
  logic        Valid;
  logic        Busy;
  logic [7:0]  ErrMask;
  logic        Timeout;

  always #5 Clock = ~Clock;

  seg7_reader #(.STABLE(4), .TIMEOUT(200)) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Seg      (Seg),
    .DigitSel (DigitSel),
    .Capture  (Capture),
    .Word     (Word),
    .Valid    (Valid),
    .Busy     (Busy),
    .ErrMask  (ErrMask),
    .Timeout  (Timeout)
  );

  // Active-high g..a patterns for hex digits 0..F
  logic [6:0] pat_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int          n_cmp = 0;
  int          n_bad = 0;
  int          valid_cnt = 0;
  int          v0;
  logic [31:0] word_at_valid = 32'h0;

  // Count Valid cycles and latch Word alongside them
  always @(negedge Clock) begin
    if (Valid) begin
      valid_cnt     <= valid_cnt + 1;
      word_at_valid <= Word;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic show(input int d, input logic [6:0] pat, input int dwell);
    DigitSel = ~(8'h01 << d);
    Seg      = ~pat;
    repeat (dwell) tick();
  endtask

  task automatic scan(input logic [31:0] w, input int dwell);
    for (int i = 0; i < 8; i++) show(i, pat_tab[w[4*i +: 4]], dwell);
  endtask

  task automatic blank();
    DigitSel = 8'hFF;
    Seg      = 7'h7F;
  endtask

  task automatic pulse_capture();
    Capture = 1'b1;
    tick();
    Capture = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int base);
    for (int k = 0; k < 20 && valid_cnt == base; k++) tick();
    repeat (3) tick();
    check_eq(tag, 32'(valid_cnt), 32'(base + 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0;
    Capture = 1'b1;
    blank();
    repeat (3) tick();
    check_eq("rst_word",    Word, 32'h0);
    check_eq("rst_valid",   32'(Valid), 32'h0);
    check_eq("rst_busy",    32'(Busy), 32'h0);
    check_eq("rst_errmask", 32'(ErrMask), 32'h0);
    check_eq("rst_timeout", 32'(Timeout), 32'h0);
    Reset_n = 1'b1;
    Capture = 1'b0;
    repeat (2) tick();
    check_eq("cap_in_reset_ignored", 32'(Busy), 32'h0);

    // Basic frame
    v0 = valid_cnt;
    pulse_capture();
    check_eq("busy_collect", 32'(Busy), 32'h1);
    scan(32'h1234_5678, 6);
    blank();
    wait_valid("basic_valid", v0);
    check_eq("basic_word_at_valid", word_at_valid, 32'h1234_5678);
    check_eq("basic_word",    Word, 32'h1234_5678);
    check_eq("basic_errmask", 32'(ErrMask), 32'h0);
    check_eq("basic_busy",    32'(Busy), 32'h0);

    // Digit 3 blank -> error, nibble 0
    v0 = valid_cnt;
    pulse_capture();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) show(i, 7'h00, 6);
      else        show(i, pat_tab[8 - i], 6);
    end
    blank();
    wait_valid("err_valid", v0);
    check_eq("err_word",    Word, 32'h1234_0678);
    check_eq("err_errmask", 32'(ErrMask), 32'h08);

    // First value wins; mid-frame Capture ignored
    v0 = valid_cnt;
    pulse_capture();
    show(0, pat_tab[10], 6);
    show(1, pat_tab[1], 6);
    show(2, pat_tab[2], 6);
    show(3, pat_tab[3], 6);
    pulse_capture();
    show(0, pat_tab[11], 6);
    for (int i = 4; i < 8; i++) show(i, pat_tab[i], 6);
    blank();
    wait_valid("first_wins_valid", v0);
    check_eq("first_wins_nibble", Word & 32'hF, 32'hA);
    check_eq("first_wins_word",   Word, 32'h7654_321A);
    check_eq("first_wins_errmask", 32'(ErrMask), 32'h0);

    // Dwell shorter than STABLE -> timeout
    v0 = valid_cnt;
    pulse_capture();
    for (int k = 0; k < 210; k++) begin
      if (k % 3 == 0) begin
        DigitSel = ~(8'h01 << ((k / 3) % 8));
        Seg      = ~pat_tab[(k / 3) % 8];
      end
      tick();
      if (k == 100) check_eq("tmo_busy_mid", 32'(Busy), 32'h1);
    end
    blank();
    check_eq("tmo_flag",  32'(Timeout), 32'h1);
    check_eq("tmo_busy",  32'(Busy), 32'h0);
    check_eq("tmo_word",  Word, 32'h7654_321A);
    check_eq("tmo_no_valid", 32'(valid_cnt), 32'(v0));

    // Two digits low are ignored
    v0 = valid_cnt;
    pulse_capture();
    check_eq("tmo_cleared", 32'(Timeout), 32'h0);
    DigitSel = 8'hFC;
    Seg      = ~pat_tab[0];
    repeat (10) tick();
    scan(32'hFFFF_FFFF, 6);
    blank();
    wait_valid("multi_valid", v0);
    check_eq("multi_word",    Word, 32'hFFFF_FFFF);
    check_eq("multi_errmask", 32'(ErrMask), 32'h0);

    // Reset mid-frame, Capture during reset ignored, then a clean frame
    v0 = valid_cnt;
    pulse_capture();
    for (int i = 0; i < 5; i++) show(i, pat_tab[i + 1], 6);
    Reset_n = 1'b0;
    Capture = 1'b1;
    tick();
    check_eq("midrst_busy",  32'(Busy), 32'h0);
    check_eq("midrst_word",  Word, 32'h0);
    check_eq("midrst_valid", 32'(Valid), 32'h0);
    Reset_n = 1'b1;
    Capture = 1'b0;
    for (int i = 5; i < 8; i++) show(i, pat_tab[i + 1], 6);
    blank();
    repeat (5) tick();
    check_eq("midrst_no_valid", 32'(valid_cnt), 32'(v0));
    check_eq("midrst_idle",     32'(Busy), 32'h0);
    pulse_capture();
    scan(32'h89AB_CDEF, 6);
    blank();
    wait_valid("after_rst_valid", v0);
    check_eq("after_rst_word", word_at_valid, 32'h89AB_CDEF);
    check_eq("after_rst_errmask", 32'(ErrMask), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
